led_scan_arbiter: RTL

Time-multiplexes N sprite layers (player, falling objects, banners) onto the shared 8×8 RGB LED matrix driver pins (active-low colour columns, 3-bit row select). Each display slot goes to one layer in round-robin order, with a dead-time blanking phase before every row switch. The block also flags new pixel overlaps between layers as one-cycle pulses. It sits between the game-object modules and the matrix pins, replacing ad-hoc per-object slot counters.

---
 rtl/led_scan_arbiter_pkg.sv | 23 ++
 rtl/led_scan_arbiter_rr_pick.sv | 35 +++
 rtl/led_scan_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/led_scan_arbiter_pkg.sv
// Shared game-side definitions for the LED matrix scan path: scan states,
// column/row constants and the default slot timing used by the divider modules.
package led_scan_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0] ALL_OFF = 8'hFF;
    localparam int ROWS  = 8;
    localparam int ROW_W = $clog2(ROWS);

    localparam int DEF_SLOT_CYC  = 10000;
    localparam int DEF_BLANK_CYC = 200;

    // Columns are active-low: a lit pixel pulls its column low when the colour is enabled.
    function automatic logic [7:0] colDrive(input logic [7:0] pix, input logic colourOn);
        return colourOn ? ~pix : ALL_OFF;
    endfunction

endpackage

// File: rtl/led_scan_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid layer after the pointer,
// wrapping around, with a flag when the pick did not move past the pointer.
module rr_pick #(
    parameter int N_LAYER = 4,
    parameter int IW      = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
    input  logic [N_LAYER-1:0] i_valid,
    input  logic [IW-1:0]      i_ptr,
    output logic [N_LAYER-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any,
    output logic               o_wrap
);

    logic [IW-1:0] w_cand;

    // Search starts one past the pointer so the last winner comes up last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_LAYER; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N_LAYER);
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

    assign o_wrap = o_any && (o_idx <= i_ptr);

endmodule

// File: rtl/led_scan_arbiter.sv
// Round-robin time multiplexing of sprite layers onto the shared 8x8 RGB
// matrix pins, with per-slot dead-time blanking and overlap-onset pulses.
module led_scan_arbiter
    import led_scan_arbiter_pkg::*;
#(
    parameter int N_LAYER   = 4,
    parameter int SLOT_CYC  = DEF_SLOT_CYC,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                   CLK,
    input  logic                   Clear,
    input  logic                   enable,
    input  logic [N_LAYER-1:0]     layer_valid,
    input  logic [3*N_LAYER-1:0]   layer_row,
    input  logic [8*N_LAYER-1:0]   layer_pix,
    input  logic [3*N_LAYER-1:0]   layer_rgb,
    output logic [7:0]             position_R,
    output logic [7:0]             position_G,
    output logic [7:0]             position_B,
    output logic [2:0]             S,
    output logic [N_LAYER-1:0]     grant,
    output logic                   frame_done,
    output logic [N_LAYER-1:0]     hit_rise
);

    localparam int IW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
    localparam int CW = $clog2(SLOT_CYC);
    localparam logic [CW-1:0] CNT_LAST_BLANK = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CNT_LAST       = CW'(SLOT_CYC - 1);

    scan_state_t        r_state;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_gidx;
    logic               r_hasWin;
    logic [N_LAYER-1:0] r_grant;
    logic [ROW_W-1:0]   r_S;
    logic [7:0]         r_posR;
    logic [7:0]         r_posG;
    logic [7:0]         r_posB;
    logic               r_frameDone;
    logic [N_LAYER-1:0] r_hitRise;
    logic [N_LAYER-1:0] r_prevOv;
    logic [7:0]         r_shPix [N_LAYER];
    logic [2:0]         r_shRgb [N_LAYER];

    logic [ROW_W-1:0]   w_row [N_LAYER];
    logic [7:0]         w_pix [N_LAYER];
    logic [2:0]         w_rgb [N_LAYER];
    logic [N_LAYER-1:0] w_overlap;
    logic [N_LAYER-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_wrap;
    logic [7:0]         w_showPix;
    logic [2:0]         w_showRgb;

    for (genvar gi = 0; gi < N_LAYER; gi++) begin : g_unpack
        assign w_row[gi] = layer_row[gi*ROW_W +: ROW_W];
        assign w_pix[gi] = layer_pix[gi*8 +: 8];
        assign w_rgb[gi] = layer_rgb[gi*3 +: 3];
    end

    rr_pick #(
        .N_LAYER (N_LAYER),
        .IW      (IW)
    ) u_pick (
        .i_valid (layer_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_wrap  (w_wrap)
    );

    // A layer overlaps when any other valid layer lights a common pixel on the same row.
    always_comb begin
        w_overlap = '0;
        for (int i = 0; i < N_LAYER; i++) begin
            for (int j = 0; j < N_LAYER; j++) begin
                if (i != j && layer_valid[j] && w_row[i] == w_row[j] &&
                    (w_pix[i] & w_pix[j]) != 8'h00) begin
                    w_overlap[i] = 1'b1;
                end
            end
        end
    end

    assign w_showPix = r_shPix[r_gidx];
    assign w_showRgb = r_shRgb[r_gidx];

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= IW'(N_LAYER - 1);
            r_gidx      <= '0;
            r_hasWin    <= 1'b0;
            r_grant     <= '0;
            r_S         <= '0;
            r_posR      <= ALL_OFF;
            r_posG      <= ALL_OFF;
            r_posB      <= ALL_OFF;
            r_frameDone <= 1'b0;
            r_hitRise   <= '0;
            r_prevOv    <= '0;
            for (int i = 0; i < N_LAYER; i++) begin
                r_shPix[i] <= '0;
                r_shRgb[i] <= '0;
            end
        end else begin
            r_frameDone <= 1'b0;
            r_hitRise   <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_posR   <= ALL_OFF;
                    r_posG   <= ALL_OFF;
                    r_posB   <= ALL_OFF;
                    r_grant  <= '0;
                    r_hasWin <= 1'b0;
                    if (enable) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                    end
                end
                ST_BLANK: begin
                    r_posR <= ALL_OFF;
                    r_posG <= ALL_OFF;
                    r_posB <= ALL_OFF;
                    // Slot start: freeze the inputs for the whole slot and hand it to the next layer.
                    if (r_cnt == '0) begin
                        for (int i = 0; i < N_LAYER; i++) begin
                            r_shPix[i] <= w_pix[i];
                            r_shRgb[i] <= w_rgb[i];
                        end
                        if (w_any) begin
                            r_ptr       <= w_idx;
                            r_gidx      <= w_idx;
                            r_grant     <= w_grant;
                            r_hasWin    <= 1'b1;
                            r_S         <= w_row[w_idx];
                            r_frameDone <= w_wrap;
                        end else begin
                            r_grant  <= '0;
                            r_hasWin <= 1'b0;
                        end
                        r_hitRise <= w_overlap & ~r_prevOv;
                        r_prevOv  <= w_overlap;
                    end
                    if (r_cnt == CNT_LAST_BLANK) begin
                        r_state <= ST_SHOW;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_SHOW: begin
                    if (r_hasWin) begin
                        r_posR <= colDrive(w_showPix, w_showRgb[2]);
                        r_posG <= colDrive(w_showPix, w_showRgb[1]);
                        r_posB <= colDrive(w_showPix, w_showRgb[0]);
                    end else begin
                        r_posR <= ALL_OFF;
                        r_posG <= ALL_OFF;
                        r_posB <= ALL_OFF;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (enable) begin
                            r_state <= ST_BLANK;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_posR   <= ALL_OFF;
                            r_posG   <= ALL_OFF;
                            r_posB   <= ALL_OFF;
                            r_grant  <= '0;
                            r_hasWin <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign position_R = r_posR;
    assign position_G = r_posG;
    assign position_B = r_posB;
    assign S          = r_S;
    assign grant      = r_grant;
    assign frame_done = r_frameDone;
    assign hit_rise   = r_hitRise;

endmodule
